bp_me_nonsynth_mem_resp_delay: RTL and testbench
================================================

Name: bp_me_nonsynth_mem_resp_delay

Overview:
In-order, per-message programmable-latency delay stage for CCE-bound memory responses. It sits between bp_mem's response port and the CCE memory response buffer in the CCE unit bench. It stretches and varies response timing to stress CCE speculative-access, writeback-overlap and buffer-full paths. Message contents pass through untouched; only timing changes.

Parameters:
width_p, 1, message width in bits (bench binds bp_bedrock_cce_mem_msg_width_lp)
els_p, 4, entry capacity; must be >= 2
max_delay_p, 255, largest accepted delay_i value
delay_width_lp, `BSG_SAFE_CLOG2(max_delay_p+1), derived width of delay_i and of each entry countdown

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous active-high reset
data_i  in  width_p  incoming response message
v_i  in  1  incoming valid; enqueue occurs when v_i & ready_o
ready_o  out  1  space available
delay_i  in  delay_width_lp  extra hold cycles for the message; sampled on enqueue
data_o  out  width_p  head message
v_o  out  1  head present and matured
yumi_i  in  1  consumer accepts head; legal only when v_o
count_o  out  `BSG_SAFE_CLOG2(els_p+1)  current occupancy

Behaviour:
- Single clock clk_i. Synchronous active-high reset_i. All state clears on reset.
- Reset values:
  - While reset_i is high and on the first cycle after it falls, v_o=0 and count_o=0.
  - ready_o=0 while reset_i is high; ready_o=1 on the first cycle after reset.
  - Reset mid-operation discards all stored entries; no message is emitted.
- Storage:
  - Circular buffer of els_p entries, with wr_ptr and rd_ptr each clog2(els_p) bits wide.
  - Each pointer wraps from els_p-1 to 0; non-power-of-2 els_p is supported.
  - Occupancy counter is 0..els_p.
  - Each entry carries a countdown cnt[i] of delay_width_lp bits.
- Enqueue at cycle t (v_i & ready_o):
  - data_i is written at wr_ptr and cnt[wr_ptr] is loaded with delay_i.
  - The message appears on v_o no earlier than cycle t+1+delay_i.
  - delay_i=0 gives one-cycle latency, because the path is registered with no combinational bypass.
- Countdown:
  - Every cycle, each occupied entry with cnt>0 decrements by 1.
  - Countdowns saturate at 0.
  - Entries count down in parallel, not only the head.
- Output:
  - v_o = (count_o!=0) & (cnt[rd_ptr]==0).
  - data_o is the entry at rd_ptr, stable while v_o=1 and no yumi_i.
  - Ordering is strict FIFO. A younger entry with a smaller delay that matures first still waits behind the head; it is released on the cycle after the head is dequeued if already at 0.
- Dequeue:
  - yumi_i dequeues the head and advances rd_ptr.
  - yumi_i without v_o is an error: it triggers an $error assertion and leaves state unchanged.
- Flow control:
  - ready_o = (count_o != els_p).
  - ready_o does not depend on yumi_i, so there is no enqueue into a full buffer even with a simultaneous dequeue.
- Simultaneous enqueue and dequeue (not full): occupancy is unchanged and both pointers advance.
  - When count_o==1 and that entry dequeues while a new one enqueues, the new entry takes effect normally.
  - v_o the next cycle follows the new entry's countdown.
- Full: when count_o==els_p, ready_o=0. Upstream holds v_i and data_i, and nothing is dropped.
- Empty: v_o=0. data_o is don't-care but must be X-free after reset (storage reset to 0).
- Range check: delay_i > max_delay_p on enqueue is an $error assertion; the value is clamped to max_delay_p.

Decomposition:
- bp_me_nonsynth_pkg gets no new typedefs. The block stays message-agnostic through width_p.
- Data storage is one bsg_mem_1r1w_sync-free register array instantiated as bsg_mem_1r1w, with asynchronous read so data_o has no extra cycle.
- Pointer, occupancy and countdown logic stay in this module; no further sub-module.
- Optional: a bench-side LFSR drives delay_i. That LFSR lives in the testbench, not here.

Test Plan:
- Single message, delay_i=0, yumi_i tied to v_o: enqueue at cycle 10 -> v_o=1 at cycle 11 with data equal to data_i; count_o returns to 0 at cycle 12.
- Single message, delay_i=5: enqueue at cycle 10 -> v_o rises at cycle 16, not earlier; data_o matches.
- Order with mismatched delays:
  - Stimulus: A with delay 6 at cycle 10, B with delay 0 at cycle 11, yumi_i always high.
  - Required: A emitted at cycle 17, B at cycle 18; B never precedes A.
- Fill and stall, els_p=4, yumi_i=0:
  - Four enqueues -> ready_o=0 and count_o=4; the fifth v_i is held.
  - One yumi_i -> ready_o=1 the next cycle; the fifth message is then accepted and emitted last.
- Simultaneous enqueue and dequeue at count_o=1 for 20 back-to-back cycles, delay 0 -> count_o stays 1; pointers wrap through 0 five times; data sequence is preserved.
- Reset asserted with 3 entries held -> v_o=0 and count_o=0 the cycle after; no stale message after release; a fresh enqueue with delay 2 emits at enqueue+3.

Source files
------------

// File: rtl/bp_me_nonsynth_mem_resp_delay_pkg.sv
// Shared helpers for the CCE memory-response delay stage.
// Holds only width math; the stage itself stays message-agnostic.
package bp_me_nonsynth_mem_resp_delay_pkg;

  // clog2 that never returns 0, so a one-entry or one-value field still gets a bit.
  function automatic int unsigned safe_clog2(input int unsigned x);
    return (x <= 1) ? 1 : $clog2(x);
  endfunction

endpackage

// File: rtl/bp_me_nonsynth_mem_resp_delay_mem.sv
// Register-array message storage: one synchronous write port, one asynchronous read port.
// Contents clear on reset so the read data is never X.
module bp_me_nonsynth_mem_resp_delay_mem
  import bp_me_nonsynth_mem_resp_delay_pkg::*;
#(
  parameter int unsigned width_p      = 1,
  parameter int unsigned els_p        = 4,
  parameter int unsigned addr_width_p = safe_clog2(els_p)
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    w_v_i,
  input  logic [addr_width_p-1:0] w_addr_i,
  input  logic [width_p-1:0]      w_data_i,
  input  logic [addr_width_p-1:0] r_addr_i,
  output logic [width_p-1:0]      r_data_o
);

  logic [width_p-1:0] mem_d [els_p];
  logic [width_p-1:0] mem_q [els_p];

  always_comb begin
    mem_d = mem_q;
    if (w_v_i) begin
      mem_d[w_addr_i] = w_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  assign r_data_o = mem_q[r_addr_i];

endmodule

// File: rtl/bp_me_nonsynth_mem_resp_delay.sv
// In-order delay stage for CCE-bound memory responses: each message is held for a
// per-message number of extra cycles, then released strictly in arrival order.
module bp_me_nonsynth_mem_resp_delay
  import bp_me_nonsynth_mem_resp_delay_pkg::*;
#(
  parameter int unsigned width_p        = 1,
  parameter int unsigned els_p          = 4,
  parameter int unsigned max_delay_p    = 255,
  parameter int unsigned delay_width_lp = safe_clog2(max_delay_p + 1),
  parameter int unsigned count_width_lp = safe_clog2(els_p + 1)
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [width_p-1:0]        data_i,
  input  logic                      v_i,
  output logic                      ready_o,
  input  logic [delay_width_lp-1:0] delay_i,
  output logic [width_p-1:0]        data_o,
  output logic                      v_o,
  input  logic                      yumi_i,
  output logic [count_width_lp-1:0] count_o
);

  localparam int unsigned ptr_width_lp = safe_clog2(els_p);
  localparam logic [ptr_width_lp-1:0] last_ptr_lp = ptr_width_lp'(els_p - 1);
  localparam logic [count_width_lp-1:0] full_count_lp = count_width_lp'(els_p);
  localparam logic [delay_width_lp-1:0] max_delay_lp = delay_width_lp'(max_delay_p);

  logic [ptr_width_lp-1:0]   wr_ptr_d, wr_ptr_q;
  logic [ptr_width_lp-1:0]   rd_ptr_d, rd_ptr_q;
  logic [count_width_lp-1:0] count_d, count_q;
  logic [delay_width_lp-1:0] cnt_d [els_p];
  logic [delay_width_lp-1:0] cnt_q [els_p];

  logic                      enq, deq, head_ripe;
  logic [31:0]               delay_ext;
  logic [delay_width_lp-1:0] delay_clamped;

  function automatic logic [ptr_width_lp-1:0] ptr_inc(input logic [ptr_width_lp-1:0] ptr);
    return (ptr == last_ptr_lp) ? '0 : ptr + ptr_width_lp'(1);
  endfunction

  // Outputs are gated by reset_i so they read idle during the reset cycle itself.
  always_comb begin
    head_ripe = (cnt_q[rd_ptr_q] == '0);
    ready_o   = ~reset_i & (count_q != full_count_lp);
    v_o       = ~reset_i & (count_q != '0) & head_ripe;
    count_o   = reset_i ? '0 : count_q;
    enq       = v_i & ready_o;
    deq       = yumi_i & v_o;
  end

  always_comb begin
    delay_ext     = 32'(delay_i);
    delay_clamped = (delay_ext > max_delay_p) ? max_delay_lp : delay_i;
  end

  // Free slots always hold a zero count (loaded only on enqueue, dequeued only at zero),
  // so decrementing every nonzero count is the same as counting down occupied entries.
  always_comb begin
    for (int unsigned i = 0; i < els_p; i++) begin
      cnt_d[i] = (cnt_q[i] != '0) ? cnt_q[i] - delay_width_lp'(1) : cnt_q[i];
    end
    if (enq) begin
      cnt_d[wr_ptr_q] = delay_clamped;
    end
  end

  always_comb begin
    wr_ptr_d = enq ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = deq ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    case ({enq, deq})
      2'b10:   count_d = count_q + count_width_lp'(1);
      2'b01:   count_d = count_q - count_width_lp'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      cnt_q    <= '{default: '0};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      cnt_q    <= cnt_d;
    end
  end

  bp_me_nonsynth_mem_resp_delay_mem #(
    .width_p     (width_p),
    .els_p       (els_p),
    .addr_width_p(ptr_width_lp)
  ) mem_1r1w (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .w_v_i   (enq),
    .w_addr_i(wr_ptr_q),
    .w_data_i(data_i),
    .r_addr_i(rd_ptr_q),
    .r_data_o(data_o)
  );

  yumi_needs_v: assert property (@(posedge clk_i) disable iff (reset_i) yumi_i |-> v_o)
    else $error("yumi_i asserted without v_o");

  delay_in_range: assert property (@(posedge clk_i) disable iff (reset_i)
      (v_i && ready_o) |-> (delay_ext <= max_delay_p))
    else $error("delay_i exceeds max_delay_p; clamped");

endmodule

// File: tb/tb_bp_me_nonsynth_mem_resp_delay.sv
// Scoreboard bench for the response delay stage: enqueue pushes the expected message and
// its release cycle; a negedge monitor pops and compares every accepted output.
module tb_bp_me_nonsynth_mem_resp_delay;

  localparam int unsigned W   = 16;
  localparam int unsigned Els = 4;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic [W-1:0]  data_i;
  logic          v_i;
  logic          ready_o;
  logic [7:0]    delay_i;
  logic [W-1:0]  data_o;
  logic          v_o;
  logic          yumi_i;
  logic [2:0]    count_o;
  logic          yumi_en;

  typedef struct {
    logic [W-1:0] data;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  bp_me_nonsynth_mem_resp_delay #(
    .width_p    (W),
    .els_p      (Els),
    .max_delay_p(255)
  ) dut (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .data_i (data_i),
    .v_i    (v_i),
    .ready_o(ready_o),
    .delay_i(delay_i),
    .data_o (data_o),
    .v_o    (v_o),
    .yumi_i (yumi_i),
    .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;
  assign yumi_i = v_o & yumi_en;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every accepted output must be the oldest outstanding message, on time.
  always @(negedge clk_i) begin
    if (!reset_i && v_o && yumi_i) begin
      if (sb.size() == 0) begin
        check("unexpected_emit", {16'h0, data_o}, 32'hdead_beef);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("emit_data", {16'h0, data_o}, {16'h0, e.data});
        if (e.cyc >= 0) check("emit_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  // Holds v_i until accepted; lat is the hand-computed release offset from the
  // accepting cycle, or -1 when only ordering matters.
  task automatic enq(input logic [W-1:0] d, input int dly, input int lat);
    int guard;
    guard   = 0;
    v_i     = 1'b1;
    data_i  = d;
    delay_i = 8'(dly);
    @(negedge clk_i);
    while (!ready_o && guard < 200) begin
      @(negedge clk_i);
      guard++;
    end
    if (!ready_o) begin
      check("enq_timeout", 32'(guard), 32'd0);
    end else begin
      sb.push_back('{data: d, cyc: (lat < 0) ? -1 : cyc + lat});
    end
    @(posedge clk_i);
    #1;
    v_i = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (sb.size() != 0 && g < 200) begin
      next_cycle();
      g++;
    end
    check("drain_left", sb.size(), 0);
    next_cycle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_i = 1'b1;
    v_i     = 1'b0;
    data_i  = '0;
    delay_i = '0;
    yumi_en = 1'b0;

    repeat (3) begin
      @(negedge clk_i);
      check("rst_v", v_o, 0);
      check("rst_count", count_o, 0);
      check("rst_ready", ready_o, 0);
    end
    next_cycle();
    reset_i = 1'b0;
    @(negedge clk_i);
    check("post_rst_v", v_o, 0);
    check("post_rst_count", count_o, 0);
    check("post_rst_ready", ready_o, 1);
    check("post_rst_data", {16'h0, data_o}, 0);
    next_cycle();

    // Zero delay: one-cycle latency, occupancy back to 0 the cycle after release.
    yumi_en = 1'b1;
    enq(16'hA001, 0, 1);
    next_cycle();
    @(negedge clk_i);
    check("d0_count_empty", count_o, 0);
    next_cycle();

    // Delay 5: release exactly 6 cycles after enqueue.
    enq(16'hB005, 5, 6);
    drain();

    // Younger short-delay message waits behind the older long one.
    enq(16'hC006, 6, 7);
    enq(16'hD000, 0, 7);
    drain();

    // Fill, stall a fifth message, free one slot, fifth goes in and out last.
    yumi_en = 1'b0;
    for (int i = 0; i < 4; i++) enq(16'hF000 + 16'(i), 0, -1);
    @(negedge clk_i);
    check("full_ready", ready_o, 0);
    check("full_count", count_o, 4);
    check("full_v", v_o, 1);
    check("full_head", {16'h0, data_o}, 32'hF000);
    fork
      enq(16'hE555, 0, -1);
      begin
        repeat (3) next_cycle();
        @(negedge clk_i);
        check("held_count", count_o, 4);
        check("held_ready", ready_o, 0);
        next_cycle();
        yumi_en = 1'b1;
        next_cycle();
        yumi_en = 1'b0;
        @(negedge clk_i);
        check("after_deq_ready", ready_o, 1);
        check("after_deq_count", count_o, 3);
      end
    join
    yumi_en = 1'b1;
    drain();

    // Back-to-back enqueue/dequeue at occupancy 1; pointers wrap five times.
    fork
      for (int i = 0; i < 20; i++) enq(16'h5000 + 16'(i), 0, 1);
      begin
        @(negedge clk_i);
        for (int i = 1; i < 20; i++) begin
          @(negedge clk_i);
          check("stream_count", count_o, 1);
        end
      end
    join
    drain();

    // Reset with entries held discards them; a fresh message still behaves normally.
    yumi_en = 1'b0;
    for (int i = 0; i < 3; i++) enq(16'h7700 + 16'(i), 10, -1);
    @(negedge clk_i);
    check("pre_rst_count", count_o, 3);
    next_cycle();
    reset_i = 1'b1;
    sb.delete();
    @(negedge clk_i);
    check("mid_rst_v", v_o, 0);
    check("mid_rst_count", count_o, 0);
    next_cycle();
    reset_i = 1'b0;
    @(negedge clk_i);
    check("rel_v", v_o, 0);
    check("rel_count", count_o, 0);
    check("rel_ready", ready_o, 1);
    yumi_en = 1'b1;
    repeat (15) next_cycle();
    enq(16'h9002, 2, 3);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
